// File: rtl/lcd_hd44780_responder_pkg.sv
// Shared constants, controller state encoding and DDRAM address helpers
// for the HD44780-class responder.
package lcd_hd44780_pkg;
    localparam logic [6:0] LINE1_FIRST = 7'h00;
    localparam logic [6:0] LINE1_LAST  = 7'h27;
    localparam logic [6:0] LINE2_FIRST = 7'h40;
    localparam logic [6:0] LINE2_LAST  = 7'h67;
    localparam logic [7:0] BLANK_CHAR  = 8'h20;
    localparam int         DDRAM_BYTES = 80;

    // Instruction decode: the highest set bit of the opcode selects the command.
    localparam int OPB_SET_DDRAM = 7;
    localparam int OPB_SET_CGRAM = 6;
    localparam int OPB_FUNC      = 5;
    localparam int OPB_SHIFT     = 4;
    localparam int OPB_DISP      = 3;
    localparam int OPB_ENTRY     = 2;
    localparam int OPB_HOME      = 1;
    localparam int OPB_CLEAR     = 0;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_FILL, ST_EXEC} lcd_state_e;

    function automatic logic ac_legal(input logic [6:0] a);
        return (a <= LINE1_LAST) || ((a >= LINE2_FIRST) && (a <= LINE2_LAST));
    endfunction

    function automatic logic [6:0] ac_next(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) r = (a == LINE1_LAST) ? LINE2_FIRST : (a == LINE2_LAST) ? LINE1_FIRST : a + 7'd1;
        else     r = (a == LINE2_FIRST) ? LINE1_LAST : (a == LINE1_FIRST) ? LINE2_LAST : a - 7'd1;
        return r;
    endfunction

    // Line 2 (0x40..0x67) packs directly after line 1 in the 80-byte store.
    function automatic logic [6:0] ddram_idx(input logic [6:0] a);
        return a[6] ? a - (LINE2_FIRST - 7'd40) : a;
    endfunction
endpackage

// File: rtl/lcd_hd44780_responder_if.sv
// Host-side LCD bus: strobe/select/data from the driver, read data and BF back.
interface lcd_hd44780_responder_if;
    logic       en;
    logic       RS;
    logic       RW;
    logic [7:0] LCD;
    logic [7:0] LCD_out;
    logic       LCD_oe;
    logic       busy;

    modport master (output en, RS, RW, LCD, input LCD_out, LCD_oe, busy);
    modport slave  (input en, RS, RW, LCD, output LCD_out, LCD_oe, busy);
endinterface

// File: rtl/lcd_en_sync.sv
// Synchronizes the asynchronous LCD bus, detects en edges and qualifies
// each transaction against the minimum enable width.
module lcd_en_sync #(
    parameter int EN_MIN_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rstBt,
    input  logic       en_i,
    input  logic       rs_i,
    input  logic       rw_i,
    input  logic [7:0] data_i,
    output logic       rise_o,
    output logic       commit_o,
    output logic       short_o,
    output logic       rs_o,
    output logic       rw_o,
    output logic [7:0] data_o
);
    localparam int            CW    = $clog2(EN_MIN_CYCLES + 1);
    localparam logic [CW-1:0] MIN_W = CW'(EN_MIN_CYCLES);

    logic [10:0]   s1_q, s2_q;
    logic          en_q;
    logic [CW-1:0] width_q;
    logic [9:0]    cap_q;
    logic          en_s, fall;

    always_ff @(posedge clk or negedge rstBt) begin
        if (!rstBt) begin
            s1_q    <= '0;
            s2_q    <= '0;
            en_q    <= 1'b0;
            width_q <= '0;
            cap_q   <= '0;
        end else begin
            s1_q <= {en_i, rs_i, rw_i, data_i};
            s2_q <= s1_q;
            en_q <= en_s;
            // Saturates at the minimum; only "long enough" matters.
            if (!en_s)                width_q <= '0;
            else if (width_q != MIN_W) width_q <= width_q + CW'(1);
            if (rise_o) cap_q <= s2_q[9:0];
        end
    end

    assign en_s     = s2_q[10];
    assign rise_o   = en_s & ~en_q;
    assign fall     = ~en_s & en_q;
    assign commit_o = fall & (width_q == MIN_W);
    assign short_o  = fall & (width_q != MIN_W);
    // Fields are visible in the rise cycle itself so read data can be launched then.
    assign {rs_o, rw_o, data_o} = rise_o ? s2_q[9:0] : cap_q;
endmodule

// File: rtl/lcd_hd44780_responder.sv
// HD44780-class display-side responder: instruction decode, 80-byte DDRAM,
// address counter, busy timing, host read-back and a debug read port.
module lcd_hd44780_responder
    import lcd_hd44780_pkg::*;
#(
    parameter int CMD_CYCLES    = 37,
    parameter int CLEAR_CYCLES  = 1520,
    parameter int EN_MIN_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rstBt,
    lcd_hd44780_responder_if.slave        bus,
    output logic [6:0]                    cursor_addr,
    output logic [2:0]                    disp_flags,
    output logic [4:0]                    mode_flags,
    input  logic [6:0]                    dbg_addr,
    output logic [7:0]                    dbg_char,
    output logic                          protocol_err
);
    localparam int            CW       = $clog2(CLEAR_CYCLES + 1);
    localparam logic [6:0]    LAST_IDX = 7'(DDRAM_BYTES - 1);

    lcd_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]  fill_q, fill_d, ac_q, ac_d;
    logic [2:0]  disp_q, disp_d;
    logic [4:0]  mode_q, mode_d;     // {I/D, S, DL, N, F}
    logic        err_q, err_d, oe_q, oe_d;
    logic [7:0]  out_q, out_d, dbg_q;
    logic [7:0]  mem_q [DDRAM_BYTES];
    logic        mem_we;
    logic [6:0]  mem_wa;
    logic [7:0]  mem_wd, rd_char;
    logic        rise, commit, short_p, rs_cur, rw_cur, busy_w;
    logic [7:0]  d;

    lcd_en_sync #(.EN_MIN_CYCLES(EN_MIN_CYCLES)) u_sync (
        .clk(clk), .rstBt(rstBt), .en_i(bus.en), .rs_i(bus.RS), .rw_i(bus.RW), .data_i(bus.LCD),
        .rise_o(rise), .commit_o(commit), .short_o(short_p), .rs_o(rs_cur), .rw_o(rw_cur), .data_o(d)
    );

    assign busy_w  = (state_q != ST_IDLE);
    assign rd_char = ac_legal(ac_q) ? mem_q[ddram_idx(ac_q)] : 8'h00;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        ac_d    = ac_q;
        disp_d  = disp_q;
        mode_d  = mode_q;
        err_d   = err_q;
        oe_d    = oe_q;
        out_d   = out_q;
        mem_we  = 1'b0;
        mem_wa  = fill_q;
        mem_wd  = BLANK_CHAR;

        unique case (state_q)
            ST_INIT, ST_FILL: begin
                mem_we = 1'b1;
                fill_d = fill_q + 7'd1;
                if (fill_q == LAST_IDX) begin
                    fill_d = '0;
                    if (state_q == ST_INIT || CLEAR_CYCLES == DDRAM_BYTES) state_d = ST_IDLE;
                    else begin
                        state_d = ST_EXEC;
                        cnt_d   = CW'(CLEAR_CYCLES - DDRAM_BYTES);
                    end
                end
            end
            ST_EXEC: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = ST_IDLE;
            end
            default: ;
        endcase

        if (rise && rw_cur) begin
            oe_d  = 1'b1;
            out_d = rs_cur ? rd_char : {busy_w, ac_q};
        end
        if (short_p) begin
            oe_d  = 1'b0;
            err_d = 1'b1;
        end

        if (commit) begin
            oe_d = 1'b0;
            if (!rw_cur) begin
                if (busy_w) err_d = 1'b1;
                else if (rs_cur) begin
                    if (ac_legal(ac_q)) begin
                        mem_we  = 1'b1;
                        mem_wa  = ddram_idx(ac_q);
                        mem_wd  = d;
                        ac_d    = ac_next(ac_q, mode_q[4]);
                        state_d = ST_EXEC;
                        cnt_d   = CW'(CMD_CYCLES);
                    end else err_d = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                    cnt_d   = CW'(CMD_CYCLES);
                    if (d[OPB_SET_DDRAM]) ac_d = d[6:0];
                    else if (d[OPB_SET_CGRAM]) begin
                        // CGRAM is not modelled; the command is only busy-timed.
                    end else if (d[OPB_FUNC]) begin
                        mode_d[2:0] = d[4:2];
                        if (!d[4]) err_d = 1'b1;
                    end else if (d[OPB_SHIFT]) begin
                        if (!d[3]) ac_d = ac_next(ac_q, d[2]);
                    end else if (d[OPB_DISP]) disp_d = d[2:0];
                    else if (d[OPB_ENTRY]) mode_d[4:3] = d[1:0];
                    else if (d[OPB_HOME]) begin
                        ac_d  = '0;
                        cnt_d = CW'(CLEAR_CYCLES);
                    end else if (d[OPB_CLEAR]) begin
                        ac_d      = '0;
                        mode_d[4] = 1'b1;
                        fill_d    = '0;
                        state_d   = ST_FILL;
                    end
                end
            end else if (rs_cur) begin
                if (ac_legal(ac_q)) ac_d = ac_next(ac_q, mode_q[4]);
                else err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstBt) begin
        if (!rstBt) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            fill_q  <= '0;
            ac_q    <= '0;
            disp_q  <= 3'b000;
            mode_q  <= 5'b10100;
            err_q   <= 1'b0;
            oe_q    <= 1'b0;
            out_q   <= 8'h00;
            dbg_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            ac_q    <= ac_d;
            disp_q  <= disp_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            oe_q    <= oe_d;
            out_q   <= out_d;
            dbg_q   <= ac_legal(dbg_addr) ? mem_q[ddram_idx(dbg_addr)] : 8'h00;
        end
    end

    // Contents are rebuilt by INIT after every reset, so the array itself is not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
    end

    assign bus.LCD_out   = out_q;
    assign bus.LCD_oe    = oe_q;
    assign bus.busy      = busy_w;
    assign cursor_addr   = ac_q;
    assign disp_flags    = disp_q;
    assign mode_flags    = mode_q;
    assign dbg_char      = dbg_q;
    assign protocol_err  = err_q;
endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed and randomized bench for lcd_hd44780_responder against a
// position-based character-display model.
module tb_lcd_hd44780_responder;
    logic       clk = 1'b0;
    logic       rstBt;
    logic [6:0] cursor_addr, dbg_addr;
    logic [2:0] disp_flags;
    logic [4:0] mode_flags;
    logic [7:0] dbg_char;
    logic       protocol_err;
    int         checks = 0, failures = 0;

    logic [7:0] m_mem [128];
    logic [6:0] m_ac;
    logic [2:0] m_disp;
    logic       m_id, m_s, m_dl, m_n, m_f, m_err;

    lcd_hd44780_responder_if bus();

    lcd_hd44780_responder dut (
        .clk(clk), .rstBt(rstBt), .bus(bus), .cursor_addr(cursor_addr), .disp_flags(disp_flags),
        .mode_flags(mode_flags), .dbg_addr(dbg_addr), .dbg_char(dbg_char), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Addresses as positions 0..79 around both lines; stepping is modular.
    function automatic logic [6:0] pos2addr(input int p);
        return (p < 40) ? 7'(p) : 7'(p + 24);
    endfunction

    function automatic logic [6:0] step(input logic [6:0] a, input logic up);
        int p;
        p = (a < 7'h40) ? int'(a) : int'(a) - 24;
        p = up ? (p + 1) % 80 : (p + 79) % 80;
        return pos2addr(p);
    endfunction

    task automatic m_blank();
        for (int p = 0; p < 80; p++) m_mem[pos2addr(p)] = 8'h20;
    endtask

    task automatic m_reset();
        m_blank();
        m_ac = 7'h00; m_disp = 3'b000; m_id = 1'b1; m_s = 1'b0;
        m_dl = 1'b1; m_n = 1'b0; m_f = 1'b0; m_err = 1'b0;
    endtask

    // Caller is on a negedge; leaves on the negedge where the commit is visible.
    task automatic xfer(input logic rs, input logic rw, input logic [7:0] d, input int w,
                        output logic [7:0] rd, output logic oe);
        bus.RS = rs; bus.RW = rw; bus.LCD = d; bus.en = 1'b1;
        repeat (w) @(negedge clk);
        rd = bus.LCD_out; oe = bus.LCD_oe;
        bus.en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 4000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 4000) chk({tag, "_timeout"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic instr(input logic [7:0] d, input int exp_busy);
        logic [7:0] rd; logic oe; int n;
        xfer(1'b0, 1'b0, d, 2, rd, oe);
        wait_idle("instr", n);
        chk($sformatf("busy_len_%02h", d), 32'(n), 32'(exp_busy));
        casez (d)
            8'b1???????: m_ac = d[6:0];
            8'b01??????: ;
            8'b001?????: begin m_dl = d[4]; m_n = d[3]; m_f = d[2]; if (!d[4]) m_err = 1'b1; end
            8'b0001????: if (!d[3]) m_ac = step(m_ac, d[2]);
            8'b00001???: m_disp = d[2:0];
            8'b000001??: begin m_id = d[1]; m_s = d[0]; end
            8'b0000001?: m_ac = 7'h00;
            8'b00000001: begin m_blank(); m_ac = 7'h00; m_id = 1'b1; end
            default: ;
        endcase
    endtask

    task automatic dwrite(input logic [7:0] c);
        logic [7:0] rd; logic oe; int n;
        xfer(1'b1, 1'b0, c, 2, rd, oe);
        wait_idle("dwrite", n);
        chk("busy_len_data", 32'(n), 32'd37);
        m_mem[m_ac] = c;
        m_ac = step(m_ac, m_id);
    endtask

    task automatic dread();
        logic [7:0] rd; logic oe;
        xfer(1'b1, 1'b1, 8'h00, 4, rd, oe);
        chk("dread_data", 32'(rd), 32'(m_mem[m_ac]));
        chk("dread_oe", 32'(oe), 32'd1);
        chk("dread_oe_off", 32'(bus.LCD_oe), 32'd0);
        m_ac = step(m_ac, m_id);
    endtask

    task automatic dbg_chk(input logic [6:0] a);
        dbg_addr = a;
        @(negedge clk);
        chk($sformatf("dbg_%02h", a), 32'(dbg_char), 32'(m_mem[a]));
    endtask

    task automatic check_mem();
        for (int p = 0; p < 80; p++) dbg_chk(pos2addr(p));
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_ac"}, 32'(cursor_addr), 32'(m_ac));
        chk({tag, "_disp"}, 32'(disp_flags), 32'(m_disp));
        chk({tag, "_mode"}, 32'(mode_flags), 32'({m_id, m_s, m_dl, m_n, m_f}));
        chk({tag, "_err"}, 32'(protocol_err), 32'(m_err));
    endtask

    task automatic do_reset_init(input int hold);
        int n;
        @(negedge clk);
        rstBt = 1'b0;
        repeat (hold) @(negedge clk);
        m_reset();
        rstBt = 1'b1;
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("init_busy_len", 32'(n), 32'd80);
    endtask

    initial begin
        logic [7:0] rd;
        logic oe;
        int n, op;
        bus.en = 1'b0; bus.RS = 1'b0; bus.RW = 1'b0; bus.LCD = 8'h00;
        dbg_addr = 7'h00; rstBt = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd1);
        chk("rst_out", 32'(bus.LCD_out), 32'd0);
        chk("rst_oe", 32'(bus.LCD_oe), 32'd0);
        check_state("rst");
        do_reset_init(2);
        dbg_chk(7'h00); dbg_chk(7'h27); dbg_chk(7'h40); dbg_chk(7'h67);

        instr(8'h38, 37); instr(8'h0C, 37); instr(8'h06, 37);
        dwrite(8'h41); dwrite(8'h42);
        dbg_chk(7'h00); dbg_chk(7'h01);
        check_state("basic");

        instr(8'hA7, 37); dwrite(8'($urandom)); check_state("wrap_up");
        dbg_chk(7'h27);
        instr(8'h04, 37); instr(8'h80, 37); dwrite(8'($urandom)); check_state("wrap_dn");
        instr(8'h06, 37);

        for (int i = 0; i < 50; i++) begin
            op = int'($urandom_range(0, 5));
            case (op)
                0: dwrite(8'($urandom));
                1: instr({1'b1, pos2addr(int'($urandom_range(0, 79)))}, 37);
                2: instr({6'b000001, 1'($urandom), 1'($urandom)}, 37);
                3: instr({5'b00010, 1'($urandom), 2'b00}, 37);
                4: dread();
                default: instr({5'b00011, 1'($urandom), 2'b00}, 37);
            endcase
            chk($sformatf("rand_ac_%0d", i), 32'(cursor_addr), 32'(m_ac));
        end
        check_mem();
        check_state("rand");

        instr(8'h01, 1520);
        check_mem();
        check_state("clear");
        instr(8'hC5, 37); instr(8'h02, 1520); check_state("home");

        // Busy read and a rejected write, both while a command is still timing out.
        xfer(1'b0, 1'b0, 8'h08, 2, rd, oe);
        m_disp = 3'b000;
        xfer(1'b0, 1'b1, 8'h00, 4, rd, oe);
        chk("bread_data", 32'(rd), 32'({1'b1, m_ac}));
        chk("bread_oe", 32'(oe), 32'd1);
        xfer(1'b0, 1'b0, 8'h0F, 2, rd, oe);
        m_err = 1'b1;
        wait_idle("busywr", n);
        check_state("busywr");

        do_reset_init(2);
        check_state("rst2");
        dwrite(8'h5A); dwrite(8'hA5);
        xfer(1'b0, 1'b0, 8'h01, 2, rd, oe);
        repeat (40) @(negedge clk);
        do_reset_init(3);
        check_mem();
        check_state("midclr");

        instr(8'h80 | 8'h05, 37);
        xfer(1'b1, 1'b0, 8'h55, 1, rd, oe);
        m_err = 1'b1;
        wait_idle("short", n);
        dbg_chk(7'h05);
        check_state("short");

        do_reset_init(2);
        instr(8'h28, 37);
        check_state("dl0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lcd_hd44780_responder.md
# lcd_hd44780_responder

Synthesizable model of the HD44780-class character-LCD controller: the display end of the interface our LCD driver blocks control. It samples en/RS/RW/LCD, decodes the 8-bit instruction set, and holds an 80-byte DDRAM. It also maintains the cursor address, mode flags and busy flag. It drives read data back on the bus and exposes a debug read port, so benches and on-board self-tests can check exactly what a driver wrote.

## Interface
- CMD_CYCLES, 37: busy duration (clk cycles) for every instruction except clear/home.
- CLEAR_CYCLES, 1520: busy duration for clear display and return home; must be ≥ 80.
- EN_MIN_CYCLES, 2: minimum synchronized en-high width. A shorter pulse is a protocol error.

- clk  in  1  system clock
- rstBt  in  1  asynchronous, active-low reset
- en  in  1  LCD enable strobe (asynchronous to clk)
- RS  in  1  register select (0 = instruction, 1 = data)
- RW  in  1  read/write (1 = read)
- LCD  in  8  bus value driven by the host
- LCD_out  out  8  read data toward the host
- LCD_oe  out  1  high while the responder drives LCD_out
- busy  out  1  busy flag (BF)
- cursor_addr  out  7  current DDRAM address counter (AC)
- disp_flags  out  3  {D, C, B} from display control
- mode_flags  out  5  {I/D, S, DL, N, F}
- dbg_addr  in  7  debug DDRAM read address
- dbg_char  out  8  DDRAM[dbg_addr], registered
- protocol_err  out  1  sticky error flag; cleared only by reset

## Operation
- en, RS, RW and LCD pass through a 2-FF synchronizer. RS/RW/LCD are captured on the synchronized en rise. A transaction commits on the synchronized en fall.
- Pulse rule: if en was high for fewer than EN_MIN_CYCLES, the transaction is discarded and protocol_err is set.
- Busy rule: a write transaction committed while busy=1 is ignored and sets protocol_err. A busy/address read is always legal.
- Write decode (RW=0, RS=0), highest set bit wins:
  - 1xxxxxxx: set AC = bits[6:0]. Legal values are 0x00–0x27 and 0x40–0x67. An illegal value is stored, and data writes/reads at it are ignored with protocol_err set.
  - 01xxxxxx: CGRAM address set; accepted and busy-timed, with no other effect.
  - 001 DL N F xx: set DL/N/F. DL=0 sets protocol_err because 4-bit mode is unsupported.
  - 0001 S/C R/L xx: with S/C=0, move AC by ±1 using wrap rules. With S/C=1 (display shift), there is no AC change.
  - 00001 D C B: set disp_flags.
  - 000001 I/D S: set entry mode.
  - 0000001x: return home; AC = 0.
  - 00000001: clear display; fill DDRAM with 0x20, AC = 0, I/D = 1.
- Data write (RW=0, RS=1): DDRAM[AC] = LCD, then AC steps by I/D.
- Busy read (RW=1, RS=0): LCD_out = {busy, AC}.
- Data read (RW=1, RS=1): LCD_out = DDRAM[AC]. AC steps on en fall. Busy is not set.
- AC wrap on increment: 0x27→0x40, 0x67→0x00. On decrement: 0x40→0x27, 0x00→0x67.
- States:
  - INIT (after reset): fill 80 bytes with 0x20, then go to IDLE.
  - IDLE.
  - FILL: clear in progress, 80 cycles, then EXEC with the remaining count.
  - EXEC: busy countdown, then IDLE.

## Timing
- Reset values:
  - busy = 1 (INIT), AC = 0.
  - disp_flags = 000.
  - mode_flags = {1, 0, 1, 0, 0}.
  - LCD_out = 0x00, LCD_oe = 0, protocol_err = 0.
- INIT lasts 80 cycles; busy falls in the cycle after the last fill write.
- Commit occurs 3 clk cycles after the raw en fall (2 synchronizer stages plus the edge register).
- busy rises in the commit cycle and stays high exactly CMD_CYCLES or CLEAR_CYCLES cycles. It falls in the cycle where the count expires.
- LCD_oe asserts 3 cycles after the raw en rise when RW=1, and deasserts in the commit cycle. LCD_out is stable for that whole window.
- dbg_char latency is 1 cycle and is independent of the host port. A simultaneous host write to the same address returns the old value.
- Reset asserted mid-clear or mid-EXEC aborts immediately. INIT restarts on release.

## Structure
- lcd_hd44780_pkg: opcode masks, DDRAM line bounds (0x00, 0x27, 0x40, 0x67), blank char 0x20, state enum, AC next-address function.
- Sub-module lcd_en_sync: 2-FF sync of the bus, rise/fall detect, pulse-width counter, min-width check.

## Test plan
- Reset release → busy=1 for 80 cycles; then dbg_char at 0x00, 0x27, 0x40 and 0x67 = 0x20; AC=0.
- Function set 0x38, display on 0x0C, entry 0x06, then data 0x41 and 0x42 → DDRAM[0x00]=0x41, DDRAM[0x01]=0x42, AC=0x02, disp_flags=100. busy high for 37 cycles after each write.
- Set AC=0xA7 (0x27), then write data → DDRAM[0x27] written and AC=0x40. With I/D=0 at AC 0x00, a write leaves AC=0x67.
- Write any instruction during busy → ignored; protocol_err=1. A busy read during busy returns LCD_out bit7=1 and LCD_oe high.
- Clear display (0x01) after writes → busy for 1520 cycles; all DDRAM = 0x20; AC=0. Reset mid-clear restarts INIT.
- A 1-cycle en pulse → transaction discarded, protocol_err=1. Function set 0x28 → protocol_err=1.
